// File: rtl/game_pkg.sv
// game_pkg: shared game state encoding and keyboard keycodes
package game_pkg;
    typedef enum logic [1:0] {
        TITLE     = 2'd0,
        PLAY      = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;
    localparam logic [7:0] KEY_ENTER = 8'd40;
    localparam logic [7:0] KEY_P     = 8'd19;
    localparam logic [7:0] KEY_W     = 8'd26;
    localparam logic [7:0] KEY_A     = 8'd4;
    localparam logic [7:0] KEY_S     = 8'd22;
    localparam logic [7:0] KEY_D     = 8'd7;
endpackage

// File: rtl/key_edge.sv
// key_edge: one-frame pulse on the first frame keycode equals KEY
module key_edge #(
    parameter logic [7:0] KEY = 8'd0
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       key_pulse
);
    logic [7:0] key_prev;
    always_ff @(posedge frame_clk) begin
        key_prev <= Reset ? 8'd0 : keycode;
    end
    assign key_pulse = (keycode == KEY) && (key_prev != KEY);
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-rate game sequencer (title, lives, respawn, invulnerability, key gating); GAME_PAUSE_EN adds P-key pause
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_FRAMES = 120,
    parameter int INVULN_FRAMES  = 180,
    parameter int OVER_FRAMES    = 300
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       player_hit,
    output logic [1:0] gameState,
    output logic [1:0] lives,
    output logic       player_reset,
    output logic       invuln,
    output logic [7:0] keycode_out,
    output logic       paused
);
    localparam logic [1:0] LIVES0 = 2'(START_LIVES);
    localparam logic [8:0] RESP0  = 9'(RESPAWN_FRAMES - 1);
    localparam logic [8:0] INV0   = 9'(INVULN_FRAMES);
    localparam logic [8:0] OVER0  = 9'(OVER_FRAMES - 1);

    game_state_t state, state_nxt;
    logic [1:0]  lives_nxt;
    logic [8:0]  timer, timer_nxt, inv_cnt, inv_nxt;
    logic [7:0]  keycode_nxt;
    logic        player_reset_nxt, paused_nxt, enter_edge, p_edge;

    key_edge #(.KEY(KEY_ENTER)) u_enter (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .key_pulse (enter_edge)
    );
`ifdef GAME_PAUSE_EN
    key_edge #(.KEY(KEY_P)) u_pause (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .key_pulse (p_edge)
    );
`else
    assign p_edge = 1'b0;
`endif

    assign gameState = state;
    assign invuln    = (inv_cnt != 9'd0);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state        <= TITLE;
            lives        <= LIVES0;
            timer        <= '0;
            inv_cnt      <= '0;
            player_reset <= 1'b0;
            paused       <= 1'b0;
            keycode_out  <= '0;
        end else begin
            state        <= state_nxt;
            lives        <= lives_nxt;
            timer        <= timer_nxt;
            inv_cnt      <= inv_nxt;
            player_reset <= player_reset_nxt;
            paused       <= paused_nxt;
            keycode_out  <= keycode_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        lives_nxt        = lives;
        timer_nxt        = timer;
        inv_nxt          = inv_cnt;
        player_reset_nxt = 1'b0;
        paused_nxt       = paused;
        keycode_nxt      = (state == PLAY && !paused) ? keycode : 8'd0;
        case (state)
            TITLE: begin
                lives_nxt = LIVES0;
                if (enter_edge) begin
                    state_nxt        = PLAY;
                    player_reset_nxt = 1'b1;
                    inv_nxt          = INV0;
                end
            end
            PLAY: begin
                paused_nxt = paused ^ p_edge;
                if (!paused) begin
                    inv_nxt = (inv_cnt != 9'd0) ? inv_cnt - 9'd1 : 9'd0;
                    // hit tests the pre-decrement count so immunity spans exactly INVULN_FRAMES
                    if (player_hit && inv_cnt == 9'd0) begin
                        lives_nxt  = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                        state_nxt  = (lives <= 2'd1) ? GAME_OVER : RESPAWN;
                        timer_nxt  = (lives <= 2'd1) ? OVER0 : RESP0;
                        paused_nxt = 1'b0;
                    end
                end
            end
            RESPAWN: begin
                timer_nxt = (timer != 9'd0) ? timer - 9'd1 : 9'd0;
                if (timer == 9'd0) begin
                    state_nxt        = PLAY;
                    player_reset_nxt = 1'b1;
                    inv_nxt          = INV0;
                end
            end
            default: begin
                timer_nxt = (timer != 9'd0) ? timer - 9'd1 : 9'd0;
                if (timer == 9'd0 || enter_edge) state_nxt = TITLE;
            end
        endcase
    end
endmodule
